// File: rtl/dps_sci_arbiter_pkg.sv
// Shared state encodings and SCI register-select constants for the
// two-master SCI register-port arbiter.
package dps_sci_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } arb_state_e;

    localparam logic [1:0]  SCI_ADDR_TX  = 2'h0;
    localparam logic [1:0]  SCI_ADDR_RX  = 2'h1;
    localparam logic [1:0]  SCI_ADDR_CFG = 2'h2;

    // Returned on a read timeout: bit31 clear reads as "RX empty".
    localparam logic [31:0] SCI_RD_TIMEOUT_DATA = 32'h0000_0000;

endpackage

// File: rtl/dps_sci_rr_arb2.sv
// Two-way round-robin grant; the last granted master loses the next tie.
module dps_sci_rr_arb2 (
    input  logic       iIF_CLOCK,
    input  logic       inRESET,
    input  logic [1:0] iREQ,
    output logic [1:0] oGNT
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        prio_d = prio_q;
        if (iREQ == 2'b11) begin
            oGNT = prio_q ? 2'b10 : 2'b01;
        end else begin
            oGNT = iREQ;
        end
        if (oGNT[0]) begin
            prio_d = 1'b1;
        end else if (oGNT[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dps_sci_arbiter.sv
// Arbitrates CPU and debug-monitor access to the SCI register port, one
// transaction outstanding, with a bounded wait on read responses.
module dps_sci_arbiter
    import dps_sci_arbiter_pkg::*;
#(
    parameter int P_RD_TIMEOUT = 16
) (
    input  logic        iIF_CLOCK,
    input  logic        inRESET,
    input  logic        iM0_REQ_VALID,
    input  logic        iM0_REQ_RW,
    input  logic [1:0]  iM0_REQ_ADDR,
    input  logic [31:0] iM0_REQ_DATA,
    output logic        oM0_REQ_BUSY,
    output logic        oM0_RD_VALID,
    output logic [31:0] oM0_RD_DATA,
    input  logic        iM1_REQ_VALID,
    input  logic        iM1_REQ_RW,
    input  logic [1:0]  iM1_REQ_ADDR,
    input  logic [31:0] iM1_REQ_DATA,
    output logic        oM1_REQ_BUSY,
    output logic        oM1_RD_VALID,
    output logic [31:0] oM1_RD_DATA,
    output logic        oSCI_REQ_VALID,
    output logic        oSCI_REQ_RW,
    output logic [1:0]  oSCI_REQ_ADDR,
    output logic [31:0] oSCI_REQ_DATA,
    input  logic        iSCI_REQ_BUSY,
    input  logic        iSCI_RD_VALID,
    input  logic [31:0] iSCI_RD_DATA,
    output logic        oSCI_RD_BUSY
);

    localparam logic [7:0] RD_LIMIT = 8'(P_RD_TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    logic        mst_q, mst_d;
    logic        rw_q, rw_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  rd_valid_q, rd_valid_d;
    logic [31:0] rd_data0_q, rd_data0_d;
    logic [31:0] rd_data1_q, rd_data1_d;

    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        can_grant;
    logic        rsp_done;
    logic [31:0] rsp_data;

    // No grant while a response pulse is on the wire, so the pointer only moves on real grants.
    assign can_grant = (state_q == ST_IDLE) && (rd_valid_q == 2'b00);
    assign arb_req   = {iM1_REQ_VALID, iM0_REQ_VALID} & {2{can_grant}};

    dps_sci_rr_arb2 u_rr_arb (
        .iIF_CLOCK (iIF_CLOCK),
        .inRESET   (inRESET),
        .iREQ      (arb_req),
        .oGNT      (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        mst_d      = mst_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wait_d     = wait_q;
        rd_valid_d = 2'b00;
        rd_data0_d = rd_data0_q;
        rd_data1_d = rd_data1_q;
        rsp_done   = 1'b0;
        rsp_data   = SCI_RD_TIMEOUT_DATA;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    mst_d   = arb_gnt[1];
                    rw_d    = arb_gnt[1] ? iM1_REQ_RW   : iM0_REQ_RW;
                    addr_d  = arb_gnt[1] ? iM1_REQ_ADDR : iM0_REQ_ADDR;
                    data_d  = arb_gnt[1] ? iM1_REQ_DATA : iM0_REQ_DATA;
                    wait_d  = 8'd0;
                    state_d = rw_d ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!iSCI_REQ_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // A response arriving on the timeout cycle still wins.
                if (iSCI_RD_VALID) begin
                    rsp_done = 1'b1;
                    rsp_data = iSCI_RD_DATA;
                end else if (wait_q == RD_LIMIT) begin
                    rsp_done = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
                if (rsp_done) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = mst_q ? 2'b10 : 2'b01;
                    if (mst_q) begin
                        rd_data1_d = rsp_data;
                    end else begin
                        rd_data0_d = rsp_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iIF_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= ST_IDLE;
            mst_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 2'b00;
            data_q     <= 32'h0;
            wait_q     <= 8'd0;
            rd_valid_q <= 2'b00;
            rd_data0_q <= 32'h0;
            rd_data1_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            mst_q      <= mst_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wait_q     <= wait_d;
            rd_valid_q <= rd_valid_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
        end
    end

    assign oM0_REQ_BUSY   = ~arb_gnt[0];
    assign oM1_REQ_BUSY   = ~arb_gnt[1];
    assign oM0_RD_VALID   = rd_valid_q[0];
    assign oM1_RD_VALID   = rd_valid_q[1];
    assign oM0_RD_DATA    = rd_data0_q;
    assign oM1_RD_DATA    = rd_data1_q;
    assign oSCI_REQ_VALID = (state_q != ST_IDLE);
    assign oSCI_REQ_RW    = rw_q;
    assign oSCI_REQ_ADDR  = addr_q;
    assign oSCI_REQ_DATA  = data_q;
    assign oSCI_RD_BUSY   = (state_q != ST_RD);

endmodule
